// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequences PC through IDLE/FETCH/HOLD, requests words from
// instruction memory and presents the registered instruction and its PC to the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] ImmExt,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        misalign_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            instr_q    <= NOP;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    // Branch operands only matter on the HOLD consume edge; everywhere else they are ignored.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = 1'b0;
        target     = pc_q + 32'd4;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    target     = PCSrc ? (pc_q + ImmExt) : (pc_q + 32'd4);
                    pc_d       = {target[31:2], 2'b00};
                    misalign_d = PCSrc && (target[1:0] != 2'b00);
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = {pc_q[31:2], 2'b00};
    assign instr_valid  = (state_q == HOLD);
    assign Instr        = instr_q;
    assign PC           = pc_q;
    assign PCPlus4      = pc_q + 32'd4;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, stalled memory, stall hold,
// branches with wrap-around, misaligned targets and reset in the middle of a fetch.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .PCSrc(PCSrc),
        .ImmExt(ImmExt),
        .stall(stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .Instr(Instr),
        .PC(PC),
        .PCPlus4(PCPlus4),
        .instr_valid(instr_valid),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input logic src, input logic [31:0] imm,
                                 input logic rdy, input logic [31:0] rdata);
        stall      = st;
        PCSrc      = src;
        ImmExt     = imm;
        imem_ready = rdy;
        imem_rdata = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
        #2;
        checkOutput("rst_req",      {31'd0, imem_req},     32'd0);
        checkOutput("rst_valid",    {31'd0, instr_valid},  32'd0);
        checkOutput("rst_pc",       PC,                    32'h0000_0000);
        checkOutput("rst_instr",    Instr,                 32'h0000_0013);
        checkOutput("rst_misalign", {31'd0, misalign_err}, 32'd0);
        tick();
        rst = 1'b0;

        // Cycle 1 after release: IDLE
        #1;
        checkOutput("idle_req",   {31'd0, imem_req},    32'd0);
        checkOutput("idle_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        checkOutput("c2_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("c2_addr", imem_addr,         32'h0000_0000);
        tick();
        checkOutput("c3_valid",   {31'd0, instr_valid}, 32'd1);
        checkOutput("c3_instr",   Instr,                32'h0050_0093);
        checkOutput("c3_pc",      PC,                   32'h0000_0000);
        checkOutput("c3_pcplus4", PCPlus4,              32'h0000_0004);
        checkOutput("c3_req",     {31'd0, imem_req},    32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
        tick();
        checkOutput("c4_addr", imem_addr,         32'h0000_0004);
        checkOutput("c4_req",  {31'd0, imem_req}, 32'd1);
        tick();
        checkOutput("pc4_instr", Instr, 32'h1111_1111);

        // Memory not ready for three cycles while fetching 0x8
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait_req",   {31'd0, imem_req},    32'd1);
            checkOutput("wait_addr",  imem_addr,            32'h0000_0008);
            checkOutput("wait_valid", {31'd0, instr_valid}, 32'd0);
            imem_rdata = 32'hBAD0_0000 + i;
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
        checkOutput("ready_addr", imem_addr, 32'h0000_0008);
        tick();
        checkOutput("cap_instr", Instr,                32'h2222_2222);
        checkOutput("cap_pc",    PC,                   32'h0000_0008);
        checkOutput("cap_valid", {31'd0, instr_valid}, 32'd1);

        // Forward branch 0x8 + 8 -> 0x10
        applyStimulus(1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h3333_3333);
        tick();
        checkOutput("br_addr", imem_addr, 32'h0000_0010);
        applyStimulus(1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h3333_3333);
        tick();
        checkOutput("h10_pc", PC, 32'h0000_0010);

        // Stall two cycles with a ready memory and pending branch operands
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h4444_4444);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stall_pc",    PC,                   32'h0000_0010);
            checkOutput("stall_instr", Instr,                32'h3333_3333);
            checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("stall_req",   {31'd0, imem_req},    32'd0);
        end
        stall = 1'b0;
        tick();
        checkOutput("back_addr", imem_addr,         32'h0000_0008);
        checkOutput("back_req",  {31'd0, imem_req}, 32'd1);

        // Branch operands in FETCH are ignored
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        tick();
        checkOutput("fetch_ign_addr", imem_addr, 32'h0000_0008);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
        tick();
        checkOutput("h08_instr", Instr, 32'h5555_5555);

        // Negative offset 0x8 - 12 wraps to 0xFFFF_FFFC, then +4 wraps to 0
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1, 32'h7777_7777);
        tick();
        checkOutput("neg_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_7777);
        tick();
        checkOutput("top_pc",      PC,      32'hFFFF_FFFC);
        checkOutput("top_pcplus4", PCPlus4, 32'h0000_0000);
        tick();
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h8888_8888);
        tick();
        checkOutput("to20_addr", imem_addr, 32'h0000_0020);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8888_8888);
        tick();
        checkOutput("h20_pc",       PC,                    32'h0000_0020);
        checkOutput("pre_misalign", {31'd0, misalign_err}, 32'd0);

        // Misaligned target 0x20 + 6 = 0x26 -> 0x24 with a one-cycle error pulse
        applyStimulus(1'b0, 1'b1, 32'h0000_0006, 1'b0, 32'h0);
        tick();
        checkOutput("mis_pc",    PC,                    32'h0000_0024);
        checkOutput("mis_addr",  imem_addr,             32'h0000_0024);
        checkOutput("mis_pulse", {31'd0, misalign_err}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("mis_clear", {31'd0, misalign_err}, 32'd0);
        checkOutput("mis_req",   {31'd0, imem_req},     32'd1);

        // Reset mid-FETCH with the memory response arriving in the same cycle
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
        rst = 1'b1;
        #1;
        checkOutput("arst_pc",    PC,                   32'h0000_0000);
        checkOutput("arst_req",   {31'd0, imem_req},    32'd0);
        checkOutput("arst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("arst_instr", Instr,                32'h0000_0013);
        tick();
        checkOutput("arst_hold_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("post_req",   {31'd0, imem_req},    32'd1);
        checkOutput("post_addr",  imem_addr,            32'h0000_0000);
        checkOutput("post_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        checkOutput("post_instr", Instr, 32'h6666_6666);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
